// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 keyboard frame receiver and key event decoder
// Optional build macro: PS2_PARITY_CHECK_EN (enables odd-parity checking of each frame)
module ps2_key_decoder #(
   parameter int CLK_FREQ_HZ = 50000000,
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_US  = 200
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [10:0] ps2_key,
   output logic        frame_error,
   output logic        busy
);

   localparam int TIMEOUT_CYC = CLK_FREQ_HZ / 1000000 * TIMEOUT_US;
   localparam int TW          = $clog2(TIMEOUT_CYC + 1);
   localparam int FW          = $clog2(FILTER_LEN + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      DONE = 2'd2
   } state_t;

   logic          clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
   logic [FW-1:0] clk_cnt_q, data_cnt_q;
   logic          clk_filt_q, data_filt_q, clk_prev_q;
   logic          sample;

   state_t        state_q, state_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [9:0]    shift_q, shift_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [10:0]   key_q, key_d;
   logic          fe_q, fe_d;
   logic          ext_q, ext_d;
   logic          rel_q, rel_d;
   logic          parity_bad;
   logic          frame_bad;

   // Two-flop synchronizers; reset to the idle-high line level
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_meta_q  <= 1'b1;
         clk_sync_q  <= 1'b1;
         data_meta_q <= 1'b1;
         data_sync_q <= 1'b1;
      end else begin
         clk_meta_q  <= ps2_clk;
         clk_sync_q  <= clk_meta_q;
         data_meta_q <= ps2_data;
         data_sync_q <= data_meta_q;
      end
   end

   // Stability filters: a new level is accepted after FILTER_LEN consecutive differing samples
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_cnt_q   <= '0;
         clk_filt_q  <= 1'b1;
         data_cnt_q  <= '0;
         data_filt_q <= 1'b1;
         clk_prev_q  <= 1'b1;
      end else begin
         clk_prev_q <= clk_filt_q;
         if (clk_sync_q == clk_filt_q) begin
            clk_cnt_q <= '0;
         end else if (clk_cnt_q == FW'(FILTER_LEN - 1)) begin
            clk_cnt_q  <= '0;
            clk_filt_q <= clk_sync_q;
         end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
         end
         if (data_sync_q == data_filt_q) begin
            data_cnt_q <= '0;
         end else if (data_cnt_q == FW'(FILTER_LEN - 1)) begin
            data_cnt_q  <= '0;
            data_filt_q <= data_sync_q;
         end else begin
            data_cnt_q <= data_cnt_q + 1'b1;
         end
      end
   end

   // A falling edge of the filtered PS/2 clock marks the bit-sample cycle
   assign sample = clk_prev_q & ~clk_filt_q;

`ifdef PS2_PARITY_CHECK_EN
   // Odd parity over the eight data bits plus the parity bit
   assign parity_bad = ~(^shift_q[8:0]);
`else
   assign parity_bad = 1'b0;
`endif

   assign frame_bad = ~shift_q[9] | parity_bad;

   // Receiver state, bit counter, shifter, timeout and event registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         timer_q   <= '0;
         key_q     <= '0;
         fe_q      <= 1'b0;
         ext_q     <= 1'b0;
         rel_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         timer_q   <= timer_d;
         key_q     <= key_d;
         fe_q      <= fe_d;
         ext_q     <= ext_d;
         rel_q     <= rel_d;
      end
   end

   // Next-state logic: frame reception, timeout abort and byte decode
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      timer_d   = timer_q;
      key_d     = key_q;
      fe_d      = 1'b0;
      ext_d     = ext_q;
      rel_d     = rel_q;
      case (state_q)
         IDLE: begin
            timer_d   = '0;
            bit_cnt_d = '0;
            if (sample && !data_filt_q) begin
               state_d = RECV;
            end
         end
         RECV: begin
            if (sample) begin
               // Bits arrive LSB first; after ten shifts [7:0]=data, [8]=parity, [9]=stop
               shift_d = {data_filt_q, shift_q[9:1]};
               timer_d = '0;
               if (bit_cnt_q == 4'd9) begin
                  state_d = DONE;
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
               state_d = IDLE;
               shift_d = '0;
               fe_d    = 1'b1;
               ext_d   = 1'b0;
               rel_d   = 1'b0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            if (frame_bad) begin
               fe_d  = 1'b1;
               ext_d = 1'b0;
               rel_d = 1'b0;
            end else if (shift_q[7:0] == 8'hE0) begin
               ext_d = 1'b1;
            end else if (shift_q[7:0] == 8'hF0) begin
               rel_d = 1'b1;
            end else begin
               key_d = {~key_q[10], ~rel_q, ext_q, shift_q[7:0]};
               ext_d = 1'b0;
               rel_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign ps2_key     = key_q;
   assign frame_error = fe_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - directed self-checking bench for ps2_key_decoder
`timescale 1ns/1ps
module tb_ps2_key_decoder;

   localparam int HALF = 20;
   localparam int GAP  = 40;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic [10:0] ps2_key;
   logic        frame_error;
   logic        busy;

   int passed = 0;
   int total = 0;
   int ev_cnt = 0;
   int fe_cnt = 0;
   logic [10:0] key_prev = '0;
   logic exp_t = 1'b0;

   ps2_key_decoder #(.CLK_FREQ_HZ(1000000), .FILTER_LEN(8), .TIMEOUT_US(200)) dut (
      .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .ps2_key(ps2_key), .frame_error(frame_error), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (reset_n && (ps2_key !== key_prev)) ev_cnt++;
      if (frame_error === 1'b1) fe_cnt++;
      key_prev = ps2_key;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [10:0] mk_key(input logic t, input logic pr, input logic ex, input logic [7:0] b);
      return {t, pr, ex, b};
   endfunction

   task automatic send_bits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = bits[i];
         wait_cyc(HALF);
         ps2_clk = 1'b0;
         wait_cyc(HALF);
         ps2_clk = 1'b1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop, output int lat);
      logic [10:0] bits;
      logic [10:0] kb;
      bits = {stop, (~^b) ^ par_flip, b, 1'b0};
      lat = -1;
      for (int i = 0; i < 11; i++) begin
         ps2_data = bits[i];
         wait_cyc(HALF);
         kb = ps2_key;
         ps2_clk = 1'b0;
         for (int k = 1; k <= HALF; k++) begin
            @(negedge clk);
            if (i == 10 && lat < 0 && ps2_key !== kb) lat = k;
         end
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      wait_cyc(GAP);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      wait_cyc(3);
      total++; if (ps2_key !== 11'h000) $display("FAIL reset_key got=%h exp=000", ps2_key); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
      total++; if (frame_error !== 1'b0) $display("FAIL reset_fe got=%b exp=0", frame_error); else passed++;
      reset_n = 1'b1;
      wait_cyc(5);
   endtask

   task automatic test_basic();
      int e0, f0, lat;
      e0 = ev_cnt; f0 = fe_cnt;
      send_frame(8'h1C, 1'b0, 1'b1, lat);
      exp_t = ~exp_t;
      total++; if (ev_cnt - e0 !== 1) $display("FAIL basic_events got=%0d exp=1", ev_cnt - e0); else passed++;
      total++; if (ps2_key !== mk_key(exp_t, 1'b1, 1'b0, 8'h1C)) $display("FAIL basic_key got=%h exp=%h", ps2_key, mk_key(exp_t, 1'b1, 1'b0, 8'h1C)); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL basic_busy got=%b exp=0", busy); else passed++;
      total++; if (fe_cnt - f0 !== 0) $display("FAIL basic_fe got=%0d exp=0", fe_cnt - f0); else passed++;
      total++; if (lat !== 12) $display("FAIL basic_latency got=%0d exp=12", lat); else passed++;
   endtask

   task automatic test_release();
      int e0, lat;
      e0 = ev_cnt;
      send_frame(8'hF0, 1'b0, 1'b1, lat);
      total++; if (ev_cnt - e0 !== 0) $display("FAIL release_prefix_events got=%0d exp=0", ev_cnt - e0); else passed++;
      send_frame(8'h1C, 1'b0, 1'b1, lat);
      exp_t = ~exp_t;
      total++; if (ev_cnt - e0 !== 1) $display("FAIL release_events got=%0d exp=1", ev_cnt - e0); else passed++;
      total++; if (ps2_key !== mk_key(exp_t, 1'b0, 1'b0, 8'h1C)) $display("FAIL release_key got=%h exp=%h", ps2_key, mk_key(exp_t, 1'b0, 1'b0, 8'h1C)); else passed++;
   endtask

   task automatic test_extended();
      int e0, lat;
      e0 = ev_cnt;
      send_frame(8'hE0, 1'b0, 1'b1, lat);
      total++; if (ev_cnt - e0 !== 0) $display("FAIL ext_prefix_events got=%0d exp=0", ev_cnt - e0); else passed++;
      send_frame(8'h75, 1'b0, 1'b1, lat);
      exp_t = ~exp_t;
      total++; if (ps2_key !== mk_key(exp_t, 1'b1, 1'b1, 8'h75)) $display("FAIL ext_key got=%h exp=%h", ps2_key, mk_key(exp_t, 1'b1, 1'b1, 8'h75)); else passed++;
      send_frame(8'h75, 1'b0, 1'b1, lat);
      exp_t = ~exp_t;
      total++; if (ps2_key !== mk_key(exp_t, 1'b1, 1'b0, 8'h75)) $display("FAIL ext_cleared_key got=%h exp=%h", ps2_key, mk_key(exp_t, 1'b1, 1'b0, 8'h75)); else passed++;
   endtask

   task automatic test_parity();
      int e0, f0, lat;
      logic [10:0] kb;
      e0 = ev_cnt; f0 = fe_cnt; kb = ps2_key;
      send_frame(8'h1C, 1'b1, 1'b1, lat);
`ifdef PS2_PARITY_CHECK_EN
      total++; if (fe_cnt - f0 !== 1) $display("FAIL parity_fe got=%0d exp=1", fe_cnt - f0); else passed++;
      total++; if (ev_cnt - e0 !== 0) $display("FAIL parity_events got=%0d exp=0", ev_cnt - e0); else passed++;
      total++; if (ps2_key !== kb) $display("FAIL parity_key got=%h exp=%h", ps2_key, kb); else passed++;
`else
      exp_t = ~exp_t;
      total++; if (fe_cnt - f0 !== 0) $display("FAIL parity_fe got=%0d exp=0", fe_cnt - f0); else passed++;
      total++; if (ev_cnt - e0 !== 1) $display("FAIL parity_events got=%0d exp=1", ev_cnt - e0); else passed++;
      total++; if (ps2_key !== mk_key(exp_t, 1'b1, 1'b0, 8'h1C)) $display("FAIL parity_key got=%h exp=%h", ps2_key, mk_key(exp_t, 1'b1, 1'b0, 8'h1C)); else passed++;
`endif
   endtask

   task automatic test_stop_error();
      int e0, f0, lat;
      logic [10:0] kb;
      send_frame(8'hF0, 1'b0, 1'b1, lat);
      e0 = ev_cnt; f0 = fe_cnt; kb = ps2_key;
      send_frame(8'h1C, 1'b0, 1'b0, lat);
      total++; if (fe_cnt - f0 !== 1) $display("FAIL stop_fe got=%0d exp=1", fe_cnt - f0); else passed++;
      total++; if (ev_cnt - e0 !== 0) $display("FAIL stop_events got=%0d exp=0", ev_cnt - e0); else passed++;
      total++; if (ps2_key !== kb) $display("FAIL stop_key got=%h exp=%h", ps2_key, kb); else passed++;
      send_frame(8'h1C, 1'b0, 1'b1, lat);
      exp_t = ~exp_t;
      total++; if (ps2_key !== mk_key(exp_t, 1'b1, 1'b0, 8'h1C)) $display("FAIL stop_flags_cleared got=%h exp=%h", ps2_key, mk_key(exp_t, 1'b1, 1'b0, 8'h1C)); else passed++;
   endtask

   task automatic test_timeout();
      int f0, lat, fe_at;
      f0 = fe_cnt;
      fe_at = -1;
      send_bits(11'b000_0101_1010, 4);
      ps2_data = 1'b1;
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      for (int i = 1; i <= 300; i++) begin
         @(negedge clk);
         if (fe_at < 0 && frame_error === 1'b1) fe_at = i;
         if (i == HALF) ps2_clk = 1'b1;
      end
      total++; if (fe_at !== 211) $display("FAIL timeout_cycle got=%0d exp=211", fe_at); else passed++;
      total++; if (fe_cnt - f0 !== 1) $display("FAIL timeout_fe_count got=%0d exp=1", fe_cnt - f0); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL timeout_busy got=%b exp=0", busy); else passed++;
      send_frame(8'h29, 1'b0, 1'b1, lat);
      exp_t = ~exp_t;
      total++; if (ps2_key !== mk_key(exp_t, 1'b1, 1'b0, 8'h29)) $display("FAIL timeout_next_key got=%h exp=%h", ps2_key, mk_key(exp_t, 1'b1, 1'b0, 8'h29)); else passed++;
   endtask

   task automatic test_reset_midframe();
      int lat, e0;
      send_bits(11'b000_0101_0110, 5);
      reset_n = 1'b0;
      wait_cyc(3);
      total++; if (ps2_key !== 11'h000 || busy !== 1'b0) $display("FAIL midreset_state got=%h/%b exp=000/0", ps2_key, busy); else passed++;
      reset_n = 1'b1;
      ps2_data = 1'b1;
      exp_t = 1'b0;
      wait_cyc(GAP);
      e0 = ev_cnt;
      total++; if (busy !== 1'b0) $display("FAIL midreset_idle_busy got=%b exp=0", busy); else passed++;
      send_frame(8'h29, 1'b0, 1'b1, lat);
      exp_t = ~exp_t;
      total++; if (ev_cnt - e0 !== 1) $display("FAIL midreset_events got=%0d exp=1", ev_cnt - e0); else passed++;
      total++; if (ps2_key !== mk_key(exp_t, 1'b1, 1'b0, 8'h29)) $display("FAIL midreset_key got=%h exp=%h", ps2_key, mk_key(exp_t, 1'b1, 1'b0, 8'h29)); else passed++;
   endtask

   task automatic test_glitch();
      int e0, f0, lat;
      logic saw_busy;
      e0 = ev_cnt; f0 = fe_cnt; saw_busy = 1'b0;
      ps2_clk = 1'b0;
      wait_cyc(2);
      ps2_clk = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (busy === 1'b1) saw_busy = 1'b1;
      end
      total++; if (saw_busy !== 1'b0) $display("FAIL glitch_busy got=%b exp=0", saw_busy); else passed++;
      total++; if (ev_cnt - e0 !== 0 || fe_cnt - f0 !== 0) $display("FAIL glitch_events got=%0d/%0d exp=0/0", ev_cnt - e0, fe_cnt - f0); else passed++;
      send_frame(8'h1C, 1'b0, 1'b1, lat);
      exp_t = ~exp_t;
      total++; if (ps2_key !== mk_key(exp_t, 1'b1, 1'b0, 8'h1C)) $display("FAIL glitch_next_key got=%h exp=%h", ps2_key, mk_key(exp_t, 1'b1, 1'b0, 8'h1C)); else passed++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_release();
      test_extended();
      test_parity();
      test_stop_error();
      test_timeout();
      test_reset_midframe();
      test_glitch();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
